fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 10 +
 rtl/q_phase_gen.sv | 39 +++
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch sequencer
package fetch_pkg;

  typedef enum logic [1:0] {Q1, Q2, Q3, Q4} q_phase_e;
  typedef enum logic {RUN, WAIT_MEM} fetch_state_e;

  localparam logic [7:0] NOP_OP      = 8'h00;
  localparam int         STACK_DEPTH = 2;

endpackage

// File: rtl/q_phase_gen.sv
// rtl/q_phase_gen.sv - Q1..Q4 phase counter with one-hot strobe decode
module q_phase_gen
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       hold,
  input  logic       q4_ready,
  output logic [1:0] q,
  output logic       clk1,
  output logic       clk2,
  output logic       clk3,
  output logic       clk4
);

  q_phase_e q_r;
  logic     adv;

  // Q4 only fires once the next opcode is on hand, so a strobe always means the phase moves.
  always_comb begin
    adv = run && !hold && ((q_r != Q4) || q4_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= Q1;
    end else if (adv) begin
      q_r <= q_phase_e'(q_r + 2'd1);
    end
  end

  assign q    = q_r;
  assign clk1 = adv && (q_r == Q1);
  assign clk2 = adv && (q_r == Q2);
  assign clk3 = adv && (q_r == Q3);
  assign clk4 = adv && (q_r == Q4);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - Q-phase strobes, opcode prefetch and jump/skip flush; FETCH_STACK_EN adds call/return
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              PC_W         = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter logic [7:0]      NOP_OP       = fetch_pkg::NOP_OP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  output logic            pmem_req,
  output logic [PC_W-1:0] pmem_addr,
  input  logic [7:0]      pmem_data,
  input  logic            pmem_valid,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_addr,
  input  logic            skip,
`ifdef FETCH_STACK_EN
  input  logic            call_en,
  input  logic            ret_en,
`endif
  output logic            clk1,
  output logic            clk2,
  output logic            clk3,
  output logic            clk4,
  output logic [7:0]      inst_reg,
  output logic            inst_valid,
  output logic [PC_W-1:0] pc
);

  fetch_state_e    state, state_nxt;
  logic [1:0]      q;
  logic [PC_W-1:0] fetch_pc;
  logic            buf_valid;
  logic [7:0]      buf_data;
  logic [1:0]      discard_cnt, discard_nxt;
  logic            live_pend;
  logic            fresh_valid;
  logic            q4_ready;
  logic [7:0]      cur_data;
  logic            jumpy;
  logic            flush;
  logic [PC_W-1:0] tgt;

  // Only the response to our own live request is accepted; anything else is stale.
  assign fresh_valid = pmem_valid && (discard_cnt == 2'd0) && live_pend;
  assign q4_ready    = buf_valid || fresh_valid;
  assign cur_data    = buf_valid ? buf_data : pmem_data;

  q_phase_gen u_q_phase_gen (
    .clk      (clk),
    .rst      (rst),
    .run      ((state == RUN) && !rst),
    .hold     (hold),
    .q4_ready (q4_ready),
    .q        (q),
    .clk1     (clk1),
    .clk2     (clk2),
    .clk3     (clk3),
    .clk4     (clk4)
  );

  assign pmem_req  = clk1;
  assign pmem_addr = fetch_pc;

`ifdef FETCH_STACK_EN
  logic [PC_W-1:0] stk [STACK_DEPTH];
  logic [1:0]      stk_cnt;
  logic [PC_W-1:0] stk_top;
  logic            do_call;
  logic            do_ret;

  assign stk_top = (stk_cnt != 2'd0) ? stk[0] : RESET_VECTOR;
  assign do_call = clk4 && !jump_en && call_en;
  assign do_ret  = clk4 && !jump_en && !call_en && ret_en;

  // stk[0] is the top; a push when full shifts the oldest entry out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= RESET_VECTOR;
      stk_cnt <= 2'd0;
    end else if (do_call) begin
      stk[0] <= fetch_pc;
      for (int i = 1; i < STACK_DEPTH; i++) stk[i] <= stk[i-1];
      if (stk_cnt != 2'(STACK_DEPTH)) stk_cnt <= stk_cnt + 2'd1;
    end else if (do_ret) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
      stk[STACK_DEPTH-1] <= RESET_VECTOR;
      if (stk_cnt != 2'd0) stk_cnt <= stk_cnt - 2'd1;
    end
  end

  assign jumpy = jump_en || call_en || ret_en;
  assign tgt   = (jump_en || call_en) ? jump_addr : stk_top;
`else
  assign jumpy = jump_en;
  assign tgt   = jump_addr;
`endif

  assign flush = jumpy || skip;

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard_cnt;
    case (state)
      RUN:      if ((q == Q4) && !hold && !q4_ready) state_nxt = WAIT_MEM;
      WAIT_MEM: if (fresh_valid) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
    if (pmem_valid && (discard_cnt != 2'd0)) discard_nxt = discard_cnt - 2'd1;
    if (clk4 && flush && live_pend && !fresh_valid && (discard_nxt != 2'd2))
      discard_nxt = discard_nxt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      inst_reg    <= NOP_OP;
      inst_valid  <= 1'b0;
      pc          <= RESET_VECTOR;
      fetch_pc    <= RESET_VECTOR;
      buf_valid   <= 1'b0;
      buf_data    <= NOP_OP;
      discard_cnt <= 2'd0;
      live_pend   <= 1'b0;
    end else begin
      state       <= state_nxt;
      discard_cnt <= discard_nxt;
      if (fresh_valid || (clk4 && flush)) live_pend <= 1'b0;
      if (clk1) live_pend <= 1'b1;
      if (clk4) begin
        buf_valid <= 1'b0;
      end else if (fresh_valid) begin
        buf_valid <= 1'b1;
        buf_data  <= pmem_data;
      end
      if (clk4) begin
        inst_reg   <= flush ? NOP_OP : cur_data;
        inst_valid <= !flush;
        pc         <= jumpy ? tgt : fetch_pc;
        fetch_pc   <= jumpy ? tgt : fetch_pc + PC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized bench for fetch_sequencer against an instruction-level model
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst, hold, pmem_req, pmem_valid, jump_en, skip;
  logic       clk1, clk2, clk3, clk4, inst_valid;
  logic [7:0] pmem_addr, pmem_data, jump_addr, inst_reg, pc;

  int         n_checks = 0;
  int         n_fail   = 0;

  logic [7:0] mem [256];
  int         due_q[$];
  logic [7:0] dat_q[$];
  int         last_due;

  int         m_ph;
  bit         m_have, m_wait;
  logic [7:0] m_fpc, m_inst, m_pc;
  logic       m_valid;

  int         hold_left, lat, exp_ph;
  bit         arrive, usable;
  logic [3:0] exp_str;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .pmem_req   (pmem_req),
    .pmem_addr  (pmem_addr),
    .pmem_data  (pmem_data),
    .pmem_valid (pmem_valid),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .skip       (skip),
    .clk1       (clk1),
    .clk2       (clk2),
    .clk3       (clk3),
    .clk4       (clk4),
    .inst_reg   (inst_reg),
    .inst_valid (inst_valid),
    .pc         (pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
    end
  endtask

  // Called just after a negedge; returns just after a later negedge with rst released.
  task automatic apply_reset();
    rst        = 1'b1;
    hold       = 1'b0;
    pmem_valid = 1'b0;
    pmem_data  = 8'h00;
    jump_en    = 1'b0;
    jump_addr  = 8'h00;
    skip       = 1'b0;
    due_q.delete();
    dat_q.delete();
    last_due = -1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_strobes", {clk4, clk3, clk2, clk1}, 4'b0000);
    check_eq("rst_req", pmem_req, 1'b0);
    check_eq("rst_inst", inst_reg, 8'h00);
    check_eq("rst_valid", inst_valid, 1'b0);
    check_eq("rst_pc", pc, 8'h00);
    rst       = 1'b0;
    m_ph      = 1;
    m_have    = 1'b0;
    m_wait    = 1'b0;
    m_fpc     = 8'h00;
    m_inst    = 8'h00;
    m_pc      = 8'h00;
    m_valid   = 1'b0;
    hold_left = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h1C;
    mem[1] = 8'h0A;
    apply_reset();
    for (int n = 0; n < 1200; n++) begin
      if (n == 700) apply_reset();

      arrive = (due_q.size() > 0) && (due_q[0] == n);
      pmem_valid = arrive;
      pmem_data  = arrive ? dat_q[0] : 8'($urandom);
      if (arrive) begin
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      if (hold_left > 0) begin
        hold = 1'b1;
        hold_left--;
      end else if (m_ph == 2 && $urandom_range(0, 9) == 0) begin
        hold = 1'b1;
        hold_left = 2;
      end else begin
        hold = 1'b0;
      end
      jump_en   = ($urandom_range(0, 7) == 0);
      jump_addr = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      skip      = ($urandom_range(0, 7) == 0);
      #1;

      // Q4 may only fire when the opcode is here; an arrival during a stall is used one cycle later.
      usable = m_have || (arrive && !m_wait);
      if (arrive) m_have = 1'b1;
      if (hold) exp_ph = 0;
      else if (m_ph == 4 && !usable) begin
        exp_ph = 0;
        m_wait = 1'b1;
      end else exp_ph = m_ph;
      exp_str = (exp_ph == 0) ? 4'b0000 : 4'(1 << (exp_ph - 1));

      check_eq("strobes", {clk4, clk3, clk2, clk1}, exp_str);
      check_eq("pmem_req", pmem_req, exp_ph == 1);
      check_eq("inst_reg", inst_reg, m_inst);
      check_eq("inst_valid", inst_valid, m_valid);
      check_eq("pc", pc, m_pc);

      if (exp_ph == 1) begin
        check_eq("pmem_addr", pmem_addr, m_fpc);
        lat = (n < 300) ? 1 : (n < 600) ? 6 : $urandom_range(1, 6);
        last_due = (n + lat > last_due) ? n + lat : last_due + 1;
        due_q.push_back(last_due);
        dat_q.push_back(mem[m_fpc]);
      end

      if (exp_ph == 4) begin
        if (jump_en) begin
          m_inst = 8'h00; m_valid = 1'b0; m_pc = jump_addr; m_fpc = jump_addr;
        end else if (skip) begin
          m_inst = 8'h00; m_valid = 1'b0; m_pc = m_fpc; m_fpc = m_fpc + 8'd1;
        end else begin
          m_inst = mem[m_fpc]; m_valid = 1'b1; m_pc = m_fpc; m_fpc = m_fpc + 8'd1;
        end
        m_have = 1'b0;
        m_wait = 1'b0;
      end
      if (exp_ph != 0) m_ph = (m_ph == 4) ? 1 : m_ph + 1;

      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
